// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU-op encodings and the multiplier FSM state type.
package cpu_pkg;

  localparam logic [1:0] ADD        = 2'b00;
  localparam logic [1:0] SUB        = 2'b01;
  localparam logic [1:0] R_TYPE     = 2'b10;
  localparam logic [1:0] MUL_OPCODE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  // Counter width for n iterations; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_iter_step.sv
// One radix-2^BITS_PER_CYCLE step of the shift-add multiplier: acc + mcand * slice.
module mul_iter_step
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic [DATA_W-1:0]         acc_i,
  input  logic [DATA_W-1:0]         mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] mplier_bits_i,
  output logic [DATA_W-1:0]         acc_next_c
);

  // Sum the shifted multiplicand for every set multiplier bit; carries past DATA_W drop.
  always_comb begin
    acc_next_c = acc_i;
    for (int unsigned b = 0; b < BITS_PER_CYCLE; b++) begin
      if (mplier_bits_i[b]) begin
        acc_next_c = acc_next_c + (mcand_i << b);
      end
    end
  end

endmodule

// File: rtl/ex_mul_unit.sv
// EX-stage iterative multiplier: low DATA_W bits of op_a*op_b, stalling upstream while busy.
module ex_mul_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              result_valid_o,
  output logic              stall_o,
  output logic              busy_o
);

  localparam int unsigned N     = DATA_W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // Reject a step size that leaves a partial slice of the multiplier.
  generate
    if ((BITS_PER_CYCLE == 0) || ((DATA_W % BITS_PER_CYCLE) != 0)) begin : g_bad_step
      $error("ex_mul_unit: BITS_PER_CYCLE must divide DATA_W");
    end
  endgenerate

  mul_state_t        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_step_c;

  mul_iter_step #(
    .DATA_W        (DATA_W),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .acc_i        (acc_q),
    .mcand_i      (mcand_q),
    .mplier_bits_i(mplier_q[BITS_PER_CYCLE-1:0]),
    .acc_next_c   (acc_step_c)
  );

  // Next-state: load on accept, shift-add while busy, flush wins in every state.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          state_d  = BUSY;
          acc_d    = '0;
          mcand_d  = op_a_i;
          mplier_d = op_b_i;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_step_c;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end
        end
      end
      // start_i is ignored here so the still-held instruction cannot re-trigger.
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decode the registered state; flush suppresses the pulse and the stall at once.
  always_comb begin
    result_valid_o = (state_q == DONE) && !flush_i;
    result_o       = result_valid_o ? acc_q : '0;
    busy_o         = (state_q != IDLE);
    stall_o        = !flush_i && (((state_q == IDLE) && start_i) || (state_q == BUSY));
  end

endmodule

// File: tb/tb_ex_mul_unit.sv
// Self-checking bench for ex_mul_unit: cycle model plus directed vectors.
module tb_ex_mul_unit;

  localparam int unsigned DATA_W = 64;
  localparam int          N      = 32;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic              flush_i;
  logic [DATA_W-1:0] op_a_i;
  logic [DATA_W-1:0] op_b_i;
  logic [DATA_W-1:0] result_o;
  logic              result_valid_o;
  logic              stall_o;
  logic              busy_o;

  int total;
  int bad;

  // Model: cycles since the accepted start (-1 when idle) and the pending product.
  int                age;
  logic [DATA_W-1:0] prod;
  bit                chk_en;

  ex_mul_unit #(.DATA_W(64), .BITS_PER_CYCLE(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .flush_i       (flush_i),
    .op_a_i        (op_a_i),
    .op_b_i        (op_b_i),
    .result_o      (result_o),
    .result_valid_o(result_valid_o),
    .stall_o       (stall_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model update at each edge, from the latency rules.
  always @(posedge clk) begin
    if (rst) begin
      age    = -1;
      chk_en = 1'b1;
    end else if (flush_i) begin
      age = -1;
    end else if (age < 0) begin
      if (start_i) begin
        age  = 1;
        prod = op_a_i * op_b_i;
      end
    end else if (age == N + 1) begin
      age = -1;
    end else begin
      age++;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic              e_valid;
      logic              e_stall;
      logic              e_busy;
      logic [DATA_W-1:0] e_res;
      e_busy  = (age >= 1);
      e_valid = (age == N + 1) && !flush_i;
      e_res   = e_valid ? prod : '0;
      e_stall = !flush_i && (((age < 0) && start_i) || ((age >= 1) && (age <= N)));
      check("m_busy",   64'(busy_o),         64'(e_busy));
      check("m_valid",  64'(result_valid_o), 64'(e_valid));
      check("m_stall",  64'(stall_o),        64'(e_stall));
      check("m_result", result_o,            e_res);
    end
  end

  task automatic advance(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a MUL with start_i held until the result cycle; check product and stall count.
  task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                         input string nm, input bit keep_start);
    int stalls;
    bit got;
    op_a_i  = a;
    op_b_i  = b;
    start_i = 1'b1;
    stalls  = 0;
    got     = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (result_valid_o) begin
        got = 1'b1;
        check({nm, "_result"}, result_o, exp);
        check({nm, "_stalls"}, 64'(stalls), 64'd33);
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout act=no_valid exp=valid_within_40", nm);
    end
    if (!keep_start) start_i = 1'b0;
  endtask

  initial begin
    int pulses;
    total   = 0;
    bad     = 0;
    age     = -1;
    prod    = '0;
    chk_en  = 1'b0;
    rst     = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_a_i  = '0;
    op_b_i  = '0;
    advance(2);
    rst = 1'b0;

    @(negedge clk);
    check("rst_busy",   64'(busy_o),         64'd0);
    check("rst_valid",  64'(result_valid_o), 64'd0);
    check("rst_stall",  64'(stall_o),        64'd0);
    check("rst_result", result_o,            64'd0);
    @(posedge clk);
    #1;

    run_mul(64'd6, 64'd7, 64'd42, "t1_6x7", 1'b0);
    advance(1);
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, "t2_wrap", 1'b0);
    run_mul(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, "t3_neg", 1'b0);

    // Back-to-back with start held through the result cycle.
    run_mul(64'd9, 64'd11, 64'd99, "t4_first", 1'b1);
    run_mul(64'd3, 64'd4, 64'd12, "t4_second", 1'b0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid_o) pulses++;
    end
    check("t4_no_third", 64'(pulses), 64'd0);
    @(posedge clk);
    #1;

    // Flush at T+10.
    op_a_i  = 64'd5;
    op_b_i  = 64'd5;
    start_i = 1'b1;
    advance(10);
    flush_i = 1'b1;
    advance(1);
    flush_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    check("t5_busy",  64'(busy_o),  64'd0);
    check("t5_stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;
    run_mul(64'd2, 64'd2, 64'd4, "t5_after", 1'b0);

    // Reset at T+20.
    op_a_i  = 64'd7;
    op_b_i  = 64'd9;
    start_i = 1'b1;
    advance(20);
    rst = 1'b1;
    advance(1);
    rst     = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    check("t6_busy",   64'(busy_o),         64'd0);
    check("t6_valid",  64'(result_valid_o), 64'd0);
    check("t6_stall",  64'(stall_o),        64'd0);
    check("t6_result", result_o,            64'd0);
    @(posedge clk);
    #1;
    run_mul(64'd0, 64'd123, 64'd0, "t6_after", 1'b0);

    // Flush landing exactly on the result cycle suppresses the pulse.
    op_a_i  = 64'd13;
    op_b_i  = 64'd17;
    start_i = 1'b1;
    advance(33);
    flush_i = 1'b1;
    @(negedge clk);
    check("fd_valid", 64'(result_valid_o), 64'd0);
    check("fd_busy",  64'(busy_o),         64'd1);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    check("fd_idle", 64'(busy_o), 64'd0);
    @(posedge clk);
    #1;

    // Flush in the start cycle prevents acceptance.
    start_i = 1'b1;
    flush_i = 1'b1;
    advance(1);
    start_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    check("fs_busy", 64'(busy_o), 64'd0);
    @(posedge clk);
    #1;

    // A few wide operands checked against the model product.
    run_mul(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
            64'h1234_5678_9ABC_DEF0 * 64'h0FED_CBA9_8765_4321, "v_wide", 1'b0);
    run_mul(64'h8000_0000_0000_0000, 64'd3, 64'h8000_0000_0000_0000, "v_msb", 1'b0);
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "v_m1sq", 1'b0);

    advance(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
